kronos_prefetch: RTL
====================

// Module: kronos_prefetch
// PURPOSE
//  Parametrised instruction prefetch stage; successor to the single-entry IF stage.
//  - Streams sequential fetches into a DEPTH-entry prefetch FIFO, decoupling IMEM grant stalls from decode back-pressure.
//  - Flushes the FIFO and redirects on branch.
//  - Sits between IMEM and the IF/ID pipe; ID consumes via pipe_vld/pipe_rdy.
// PARAMETERS
//  PC_START  32'h0  reset fetch address (word aligned)
//  DEPTH     2      prefetch FIFO entries; power of 2, >=2
// PORTS
//  clk            in   1             clock, all flops posedge
//  rst            in   1             asynchronous, active-high reset
//  instr_addr     out  32            IMEM fetch address, [1:0] always 2'b00
//  instr_req      out  1             fetch request
//  instr_gnt      in   1             grant; instr_data valid in the same cycle
//  instr_data     in   32            fetched instruction word
//  pipe_IFID      out  pipeIFID_t    {pc, ir} at FIFO head
//  pipe_vld       out  1             head entry valid
//  pipe_rdy       in   1             ID accepts head
//  branch_target  in   32            redirect address; [1:0] ignored
//  branch         in   1             redirect/flush strobe, single cycle
//  fifo_count     out  $clog2(DEPTH+1)  occupied entries (debug/perf)
// BEHAVIOUR
//  Reset values:
//  - pc=PC_START, state=INIT, FIFO empty, fifo_count=0.
//  - pipe_vld=0, instr_req=0, pipe_IFID='0, instr_addr=PC_START.
//  - Reset mid-operation drops all entries and in-flight grants immediately.
//  FSM:
//  - INIT -> RUN unconditionally; INIT lasts 1 cycle, no req.
//  - RUN -> FULL when push && !pop && fifo_count==DEPTH-1.
//  - FULL -> RUN on pop or branch.
//  - branch in any non-INIT state -> RUN.
//  instr_req = (state==RUN) && !branch.
//  - Never depends combinationally on pipe_rdy.
//  - Held with a stable instr_addr until granted.
//  instr_addr = pc. Word aligned: branch_target[1:0] is treated as 2'b00.
//  push = instr_req && instr_gnt:
//  - FIFO writes {pc, instr_data}.
//  - pc <= pc+4; wraps 32'hFFFF_FFFC -> 0 modulo 2^32.
//  pop = pipe_vld && pipe_rdy. Simultaneous push+pop leaves count unchanged.
//  Pointers:
//  - $clog2(DEPTH) bits, wrap naturally.
//  - Overflow is impossible because req is gated by FULL state; underflow because pop is gated by pipe_vld.
//  branch (priority over push and pop in that cycle):
//  - FIFO cleared, fifo_count=0, pipe_vld=0 next cycle.
//  - Any same-cycle grant is discarded.
//  - pc <= {branch_target[31:2],2'b00}.
//  - First req at the target in cycle N+1.
//  - Back-to-back branches: the last one wins.
//  Latency (no bypass):
//  - grant at N -> pipe_vld at N+1.
//  - branch at N -> earliest target pipe_vld at N+2.
//  Sustained throughput: 1 instr/cycle when gnt=1 and pipe_rdy=1, because DEPTH>=2 avoids a full bubble.
//  pipe_IFID is a registered FIFO output. It holds stable while pipe_vld && !pipe_rdy.
// CONFIGURATION
//  KRONOS_PREFETCH_BYPASS_EN defined:
//  - When the FIFO is empty and push occurs, pipe_vld=1 and pipe_IFID={pc,instr_data} in the same cycle (combinational).
//  - If pipe_rdy=1 that cycle, the entry is consumed without being written.
//  - Otherwise it is written normally.
//  - Branch->target pipe_vld latency becomes N+1.
//  Undefined: no combinational IMEM->pipe path; all outputs registered/FIFO-sourced as above.
// TESTING
//  1 Reset release, gnt=1, pipe_rdy=1
//    -> addr 0,4,8,... on consecutive cycles; pipe_IFID.pc 0,4,8 with ir matching data.
//    -> 1 instr/cycle after fill, no bubbles.
//  2 pipe_rdy=0, gnt=1
//    -> exactly DEPTH (2) pushes, then FULL with instr_req=0, fifo_count=2.
//    -> pipe_rdy=1 drains in order pc 0,4; req resumes at 8.
//  3 FIFO holding pc 0x10,0x14; branch=1 target 0x103 with gnt=1
//    -> grant discarded, count=0, next addr 0x100.
//    -> next pipe_IFID.pc=0x100 (N+2; N+1 with BYPASS_EN).
//  4 gnt toggled 1,0,0,1 with pipe_rdy random
//    -> addr held during gnt=0; no duplicated or dropped pc; order preserved.
//  5 pc=32'hFFFF_FFFC granted
//    -> next addr 0x0.
//    -> Async rst asserted mid-stream: pipe_vld=0 and instr_req=0 immediately; restart at PC_START.
//  6 Simultaneous push+pop at count=1 -> count stays 1.
//    -> Repeat suite with DEPTH=4 and KRONOS_PREFETCH_BYPASS_EN.

Source files
------------

// File: rtl/kronos_prefetch.sv
// kronos_prefetch: instruction prefetch stage streaming sequential IMEM fetches into a DEPTH-entry FIFO.
//   Package kronos_prefetch_pkg provides pipeIFID_t = {pc, ir}.
//   Parameters: PC_START (reset fetch address), DEPTH (FIFO entries, power of 2, >=2).
//   Optional macro KRONOS_PREFETCH_BYPASS_EN: an empty FIFO forwards a granted fetch
//   combinationally to the ID side in the same cycle.
//   Ports:
//     clk, rst                          clock; asynchronous active-high reset
//     instr_addr/instr_req              IMEM fetch address (word aligned) and request
//     instr_gnt/instr_data              IMEM grant with same-cycle data
//     pipe_IFID/pipe_vld/pipe_rdy       FIFO head {pc, ir} towards ID, valid/ready handshake
//     branch_target/branch              redirect address and single-cycle flush strobe
//     fifo_count                        occupied FIFO entries
package kronos_prefetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;
endpackage

module kronos_prefetch
    import kronos_prefetch_pkg::*;
#(
    parameter logic [31:0] PC_START = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                instr_addr,
    output logic                       instr_req,
    input  logic                       instr_gnt,
    input  logic [31:0]                instr_data,
    output pipeIFID_t                  pipe_IFID,
    output logic                       pipe_vld,
    input  logic                       pipe_rdy,
    input  logic [31:0]                branch_target,
    input  logic                       branch,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {INIT, RUN, FULL} state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc;
    pipeIFID_t       mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic            empty, push, pop, wr, rd;

    assign empty      = count == '0;
    assign instr_addr = pc;
    // FULL state gates the request, so the FIFO can never overflow
    assign instr_req  = state == RUN && !branch;
    assign push       = instr_req && instr_gnt;
    assign pop        = pipe_vld && pipe_rdy;
    assign fifo_count = count;

`ifdef KRONOS_PREFETCH_BYPASS_EN
    logic byp;
    assign byp       = push && empty;
    assign pipe_vld  = !empty || byp;
    assign pipe_IFID = empty ? pipeIFID_t'({pc, instr_data}) : mem[rptr];
    // a bypassed word taken by ID in the same cycle never touches the FIFO
    assign wr        = push && !(byp && pipe_rdy);
    assign rd        = pop && !empty;
`else
    assign pipe_vld  = !empty;
    assign pipe_IFID = mem[rptr];
    assign wr        = push;
    assign rd        = pop;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = RUN;
            RUN:     state_nxt = (push && !pop && count == CW'(DEPTH-1)) ? FULL : RUN;
            FULL:    state_nxt = pop ? RUN : FULL;
            default: state_nxt = INIT;
        endcase
        if (branch && state != INIT)
            state_nxt = RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            pc    <= PC_START;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            state <= state_nxt;
            if (branch) begin
                // branch wins over any same-cycle grant or pop
                pc    <= branch_target & ~32'd3;
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push)
                    pc <= pc + 32'd4;
                if (wr) begin
                    mem[wptr] <= pipeIFID_t'({pc, instr_data});
                    wptr      <= wptr + 1'b1;
                end
                if (rd)
                    rptr <= rptr + 1'b1;
                count <= count + CW'(wr) - CW'(rd);
            end
        end
    end
endmodule
